// File: rtl/serial_tx8.sv
// serial_tx8: 8-bit serial transmitter, frame = start(0), 8 data bits LSB first, stop(1).
// Every bit is held for BIT_CYCLES clocks. All outputs are registered.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   data_in  parallel byte, captured only when a load is accepted
//   load     transmit request, accepted only while ready=1
//   ready    idle and able to accept load
//   busy     frame in progress on sout
//   done     one-cycle pulse in the last stop-bit cycle
//   sout     serial line, idles high
module serial_tx8 #(
   parameter int unsigned BIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       load,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       sout
);

   // Counter must hold BIT_CYCLES-1; keep at least one bit so BIT_CYCLES=1 still builds.
   localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [2:0]       bit_idx, bit_idx_d;
   logic [7:0]       shreg, shreg_d;
   logic             bit_end;

   logic             sout_d;
   logic             ready_d;
   logic             busy_d;
   logic             done_d;

   assign bit_end = (cnt == CNT_LAST);

   // State and output registers; outputs are loaded from values decoded off the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         sout    <= 1'b1;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shreg   <= shreg_d;
         sout    <= sout_d;
         ready   <= ready_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Next-state logic: bit timing, bit index and shift register.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_idx_d = bit_idx;
      shreg_d   = shreg;
      case (state)
         IDLE: begin
            if (load) begin
               state_d   = START;
               cnt_d     = '0;
               bit_idx_d = '0;
               shreg_d   = data_in;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shreg_d = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx + 3'd1;
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the next state so registered outputs line up with the state they describe.
   always_comb begin
      sout_d  = 1'b1;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      case (state_d)
         IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         START: sout_d = 1'b0;
         DATA:  sout_d = shreg_d[0];
         STOP:  done_d = (cnt_d == CNT_LAST);
         default: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_tx8.sv
// tb_serial_tx8: directed and randomized bench for serial_tx8 at BIT_CYCLES=4 and BIT_CYCLES=1.
// The expected line waveform is built from the frame definition as a queue of levels.
module tb_serial_tx8;

   logic       clk;
   logic       rst4, ld4, rst1, ld1;
   logic [7:0] din4, din1;
   logic       rdy4, bsy4, dn4, so4;
   logic       rdy1, bsy1, dn1, so1;

   int checks = 0;
   int errors = 0;

   serial_tx8 #(.BIT_CYCLES(4)) dut4 (
      .clk     (clk),
      .rst     (rst4),
      .data_in (din4),
      .load    (ld4),
      .ready   (rdy4),
      .busy    (bsy4),
      .done    (dn4),
      .sout    (so4)
   );

   serial_tx8 #(.BIT_CYCLES(1)) dut1 (
      .clk     (clk),
      .rst     (rst1),
      .data_in (din1),
      .load    (ld1),
      .ready   (rdy1),
      .busy    (bsy1),
      .done    (dn1),
      .sout    (so1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit expired, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int k, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic chk_outs(input bit sel, input string tag, input int k,
                           input logic es, input logic er, input logic eb, input logic ed);
      logic s, r, b, d;
      s = sel ? so1  : so4;
      r = sel ? rdy1 : rdy4;
      b = sel ? bsy1 : bsy4;
      d = sel ? dn1  : dn4;
      chk({tag, ".sout"},  k, s, es);
      chk({tag, ".ready"}, k, r, er);
      chk({tag, ".busy"},  k, b, eb);
      chk({tag, ".done"},  k, d, ed);
   endtask

   task automatic drive(input bit sel, input logic l, input logic [7:0] d);
      if (sel) begin
         ld1  = l;
         din1 = d;
      end else begin
         ld4  = l;
         din4 = d;
      end
   endtask

   // Send one frame from IDLE; optional extra load pulse at frame cycle pulse_at (0 = none).
   // data_in is scrambled every cycle after acceptance.
   task automatic send(input bit sel, input logic [7:0] d, input int pulse_at,
                       input logic [7:0] pulse_data, input string tag);
      int         bc;
      logic       exp_q[$];
      logic [9:0] fr;
      bc = sel ? 1 : 4;
      fr = {1'b1, d, 1'b0};
      for (int b = 0; b < 10; b++)
         for (int c = 0; c < bc; c++)
            exp_q.push_back(fr[b]);
      drive(sel, 1'b1, d);
      for (int k = 1; k <= 10 * bc; k++) begin
         tick();
         if (k == pulse_at) drive(sel, 1'b1, pulse_data);
         else               drive(sel, 1'b0, 8'($urandom));
         chk_outs(sel, tag, k, exp_q.pop_front(), 1'b0, 1'b1, (k == 10 * bc));
      end
      tick();
      chk_outs(sel, {tag, ".after"}, 10 * bc + 1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [9:0] fr81;
      logic [7:0] rb;
      int         pa;

      rst4 = 1'b1; rst1 = 1'b1;
      ld4  = 1'b0; ld1  = 1'b0;
      din4 = 8'($urandom); din1 = 8'($urandom);

      // Reset state
      repeat (3) tick();
      chk_outs(1'b0, "reset4", 0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_outs(1'b1, "reset1", 0, 1'b1, 1'b1, 1'b0, 1'b0);
      rst4 = 1'b0; rst1 = 1'b0;

      // Idle for 20 cycles
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk_outs(1'b0, "idle", k, 1'b1, 1'b1, 1'b0, 1'b0);
      end

      // Single frame 8'hA5
      send(1'b0, 8'hA5, 0, 8'h00, "a5");

      // 8'h3C with a dropped load of 8'hFF during DATA
      send(1'b0, 8'h3C, 12, 8'hFF, "3c_drop");

      // Abort mid-frame: rst asserted during frame cycle 15
      drive(1'b0, 1'b1, 8'h00);
      for (int k = 1; k <= 15; k++) begin
         tick();
         drive(1'b0, 1'b0, 8'($urandom));
         chk_outs(1'b0, "abort_pre", k, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      rst4 = 1'b1;
      tick();
      chk_outs(1'b0, "abort_rst", 16, 1'b1, 1'b1, 1'b0, 1'b0);
      rst4 = 1'b0;
      for (int k = 17; k <= 60; k++) begin
         tick();
         chk_outs(1'b0, "abort_idle", k, 1'b1, 1'b1, 1'b0, 1'b0);
      end

      // rst and load at the same edge: no frame starts
      rst4 = 1'b1;
      drive(1'b0, 1'b1, 8'($urandom));
      tick();
      chk_outs(1'b0, "rst_vs_load", 1, 1'b1, 1'b1, 1'b0, 1'b0);
      rst4 = 1'b0;
      drive(1'b0, 1'b0, 8'($urandom));
      for (int k = 2; k <= 6; k++) begin
         tick();
         chk_outs(1'b0, "rst_vs_load", k, 1'b1, 1'b1, 1'b0, 1'b0);
      end

      // Randomized frames at BIT_CYCLES=4 with random ignored load pulses
      repeat (6) begin
         rb = 8'($urandom);
         pa = int'($urandom_range(0, 39));
         send(1'b0, rb, pa, 8'($urandom), "rand4");
      end

      // BIT_CYCLES=1, load held high with 8'h81: repeating frames, one IDLE cycle between
      fr81 = {1'b1, 8'h81, 1'b0};
      drive(1'b1, 1'b1, 8'h81);
      for (int f = 0; f < 3; f++) begin
         for (int k = 1; k <= 10; k++) begin
            tick();
            chk_outs(1'b1, "held81", k, fr81[k-1], 1'b0, 1'b1, (k == 10));
         end
         tick();
         chk_outs(1'b1, "held81_gap", 11, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      drive(1'b1, 1'b0, 8'h00);
      tick();
      chk_outs(1'b1, "held81_end", 12, 1'b1, 1'b1, 1'b0, 1'b0);

      // Randomized frames at BIT_CYCLES=1
      repeat (6) begin
         rb = 8'($urandom);
         pa = int'($urandom_range(0, 9));
         send(1'b1, rb, pa, 8'($urandom), "rand1");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
